// File: rtl/st_align_byhawo.sv
// Store alignment: shifts store data/byte-enables onto word lanes and issues 1-2 write beats.
// Define MISALIGN_SPLIT_EN to split word-crossing stores; otherwise they are rejected.
module st_align_byhawo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [3:0]  st_mask_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_bmask_o,
    output logic        st_done_o,
    output logic        st_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_done;
    logic        r_err;
    logic        r_split;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic [31:0] r_hi_addr;
    logic [31:0] r_hi_data;
    logic [3:0]  r_hi_mask;

    logic        w_legal;
    logic        w_split;
    logic        w_reject;
    logic [31:0] w_data;
    logic [31:0] w_base;
    logic [63:0] w_sdata;
    logic [7:0]  w_smask;

    always_comb begin
        w_legal = (st_mask_i == 4'b0001) ||
                  (st_mask_i == 4'b0011) ||
                  (st_mask_i == 4'b1111);
        // Bits above the access size are dropped before shifting.
        w_data  = st_data_i & {{8{st_mask_i[3]}}, {8{st_mask_i[2]}},
                               {8{st_mask_i[1]}}, {8{st_mask_i[0]}}};
        w_base  = {st_addr_i[31:2], 2'b00};
        w_sdata = {32'd0, w_data} << {st_addr_i[1:0], 3'b000};
        w_smask = {4'd0, st_mask_i} << st_addr_i[1:0];
        w_split = |w_smask[7:4];
`ifdef MISALIGN_SPLIT_EN
        w_reject = !w_legal;
`else
        w_reject = !w_legal || w_split;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_split   <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_bmask   <= 4'd0;
            r_hi_addr <= 32'd0;
            r_hi_data <= 32'd0;
            r_hi_mask <= 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (st_valid_i) begin
                        r_split   <= w_split;
                        r_hi_addr <= w_base + 32'd4;
                        r_hi_data <= w_sdata[63:32];
                        r_hi_mask <= w_smask[7:4];
                        if (w_reject) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_BEAT0;
                            r_valid <= 1'b1;
                            r_addr  <= w_base;
                            r_wdata <= w_sdata[31:0];
                            r_bmask <= w_smask[3:0];
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ready_i) begin
                        if (r_split) begin
                            r_state <= S_BEAT1;
                            r_addr  <= r_hi_addr;
                            r_wdata <= r_hi_data;
                            r_bmask <= r_hi_mask;
                        end else begin
                            r_state <= S_RESP;
                            r_valid <= 1'b0;
                            r_addr  <= 32'd0;
                            r_wdata <= 32'd0;
                            r_bmask <= 4'd0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready_i) begin
                        r_state <= S_RESP;
                        r_valid <= 1'b0;
                        r_addr  <= 32'd0;
                        r_wdata <= 32'd0;
                        r_bmask <= 4'd0;
                        r_done  <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign st_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign mem_valid_o = r_valid;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_bmask_o = r_bmask;
    assign st_done_o   = r_done;
    assign st_err_o    = r_err;

endmodule

// File: tb/tb_st_align_byhawo.sv
// Scoreboard bench for st_align_byhawo: directed stores, expected beats/responses queued.
module tb_st_align_byhawo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        st_valid_i = 1'b0;
    logic        st_ready_o;
    logic [31:0] st_addr_i = 32'd0;
    logic [31:0] st_data_i = 32'd0;
    logic [3:0]  st_mask_i = 4'd0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_bmask_o;
    logic        st_done_o;
    logic        st_err_o;

    st_align_byhawo dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_mask_i(st_mask_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_bmask_o(mem_bmask_o),
        .st_done_o(st_done_o), .st_err_o(st_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats_seen = 0;
    int stall_left = 0;
    int hold_at_beat = -1;

    logic [67:0] exp_beat[$];
    int          exp_kind[$];
    int          exp_cyc[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory-side ready driver
    always @(posedge clk_i) begin
        #1;
        if (mem_valid_o && (stall_left > 0 || beats_seen == hold_at_beat)) begin
            mem_ready_i = 1'b0;
            if (stall_left > 0) stall_left = stall_left - 1;
        end else begin
            mem_ready_i = 1'b1;
        end
    end

    // Monitor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_valid_o && mem_ready_i) begin
                logic [67:0] e;
                checks++;
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h/%h/%b, none expected",
                             mem_addr_o, mem_wdata_o, mem_bmask_o);
                end else begin
                    e = exp_beat.pop_front();
                    if ({mem_addr_o, mem_wdata_o, mem_bmask_o} !== e) begin
                        errors++;
                        $display("FAIL beat: got %h/%h/%b, expected %h/%h/%b",
                                 mem_addr_o, mem_wdata_o, mem_bmask_o,
                                 e[67:36], e[35:4], e[3:0]);
                    end
                end
            end
            if (!mem_valid_o) begin
                checks++;
                if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0 || mem_bmask_o !== 4'd0) begin
                    errors++;
                    $display("FAIL idle_zero: got %h/%h/%b, expected 0/0/0",
                             mem_addr_o, mem_wdata_o, mem_bmask_o);
                end
            end
            if (st_done_o || st_err_o) begin
                int k;
                int c;
                checks++;
                if (exp_kind.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: done=%b err=%b cyc=%0d",
                             st_done_o, st_err_o, cyc);
                end else begin
                    k = exp_kind.pop_front();
                    c = exp_cyc.pop_front();
                    if (st_done_o !== (k == 1) || st_err_o !== (k == 0) || cyc != c) begin
                        errors++;
                        $display("FAIL resp: got done=%b err=%b cyc=%0d, expected %s at cyc=%0d",
                                 st_done_o, st_err_o, cyc, (k == 1) ? "done" : "err", c);
                    end
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_beat.push_back({a, d, m});
    endtask

    // kind: 1 = done, 0 = err, -1 = none; lat counted from cycle after accept edge
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input int stall,
                            input int kind, input int lat, input bit wait_end);
        int t;
        t = 0;
        while (!st_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        stall_left = stall;
        st_addr_i  = a;
        st_data_i  = d;
        st_mask_i  = m;
        st_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        st_valid_i = 1'b0;
        if (kind >= 0) begin
            exp_kind.push_back(kind);
            exp_cyc.push_back(cyc + lat);
        end
        if (wait_end) begin
            t = 0;
            while ((exp_kind.size() != 0 || exp_beat.size() != 0) && t < 60) begin
                @(negedge clk_i);
                t++;
            end
            checks++;
            if (t >= 60) begin
                errors++;
                $display("FAIL timeout: addr %h left beats=%0d resps=%0d, expected 0/0",
                         a, exp_beat.size(), exp_kind.size());
                exp_beat.delete();
                exp_kind.delete();
                exp_cyc.delete();
            end
            @(negedge clk_i);
            stall_left = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        checks++;
        if (st_ready_o !== 1'b0 || mem_valid_o !== 1'b0 || st_done_o !== 1'b0 ||
            st_err_o !== 1'b0 || mem_bmask_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b done=%b err=%b, expected all 0",
                     st_ready_o, mem_valid_o, st_done_o, st_err_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (st_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 1", st_ready_o);
        end

        push_beat(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        do_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 0, 1, 1, 1);

        push_beat(32'h0000_2000, 32'hA500_0000, 4'b1000);
        do_store(32'h0000_2003, 32'hFFFF_FFA5, 4'b0001, 0, 1, 1, 1);

`ifdef MISALIGN_SPLIT_EN
        push_beat(32'h0000_3000, 32'hEF00_0000, 4'b1000);
        push_beat(32'h0000_3004, 32'h0000_00BE, 4'b0001);
        do_store(32'h0000_3003, 32'h0000_BEEF, 4'b0011, 0, 1, 2, 1);

        push_beat(32'h0000_4000, 32'hBEEF_0000, 4'b1100);
        push_beat(32'h0000_4004, 32'h0000_DEAD, 4'b0011);
        do_store(32'h0000_4002, 32'hDEAD_BEEF, 4'b1111, 3, 1, 5, 1);

        push_beat(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        push_beat(32'h0000_0000, 32'h0000_1122, 4'b0011);
        do_store(32'hFFFF_FFFE, 32'h1122_3344, 4'b1111, 0, 1, 2, 1);
`else
        do_store(32'h0000_3003, 32'h0000_BEEF, 4'b0011, 0, 0, 0, 1);
        do_store(32'h0000_4002, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 1);
        do_store(32'hFFFF_FFFE, 32'h1122_3344, 4'b1111, 0, 0, 0, 1);
`endif

        do_store(32'h0000_5000, 32'h1234_5678, 4'b0101, 0, 0, 0, 1);
        do_store(32'h0000_5004, 32'h1234_5678, 4'b0000, 0, 0, 0, 1);
        do_store(32'h0000_5008, 32'h1234_5678, 4'b0111, 0, 0, 0, 1);

        push_beat(32'h0000_6000, 32'h00AB_CD00, 4'b0110);
        do_store(32'h0000_6001, 32'h1234_ABCD, 4'b0011, 0, 1, 1, 1);

        push_beat(32'h0000_6000, 32'h5678_0000, 4'b1100);
        do_store(32'h0000_6002, 32'hFFFF_5678, 4'b0011, 0, 1, 1, 1);

        push_beat(32'h0000_7000, 32'h0000_0078, 4'b0001);
        do_store(32'h0000_7000, 32'h1234_5678, 4'b0001, 0, 1, 1, 1);

        push_beat(32'h0000_7004, 32'h0000_5600, 4'b0010);
        do_store(32'h0000_7005, 32'h1234_5656, 4'b0001, 2, 1, 3, 1);

        // Reset while a beat is stalled
`ifdef MISALIGN_SPLIT_EN
        hold_at_beat = beats_seen + 1;
        push_beat(32'h0000_4000, 32'hBEEF_0000, 4'b1100);
        do_store(32'h0000_4002, 32'hDEAD_BEEF, 4'b1111, 0, -1, 0, 0);
`else
        hold_at_beat = beats_seen;
        do_store(32'h0000_8000, 32'hCAFE_F00D, 4'b1111, 0, -1, 0, 0);
`endif
        repeat (4) @(negedge clk_i);
        checks++;
        if (mem_valid_o !== 1'b1 || mem_bmask_o !== 4'b0011 && mem_bmask_o !== 4'b1111) begin
            errors++;
            $display("FAIL stalled_beat: valid=%b bmask=%b, expected valid 1 with beat held",
                     mem_valid_o, mem_bmask_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        hold_at_beat = -1;
        @(negedge clk_i);
        checks++;
        if (mem_valid_o !== 1'b0 || st_ready_o !== 1'b1 || st_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_beat: valid=%b ready=%b done=%b, expected 0/1/0",
                     mem_valid_o, st_ready_o, st_done_o);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_beat.size() != 0 || exp_kind.size() != 0) begin
            errors++;
            $display("FAIL reset_leftover: beats=%0d resps=%0d, expected 0/0",
                     exp_beat.size(), exp_kind.size());
        end

        push_beat(32'h0000_9000, 32'h0BAD_F00D, 4'b1111);
        do_store(32'h0000_9000, 32'h0BAD_F00D, 4'b1111, 0, 1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/st_align_byhawo.md
# st_align_byhawo

Store-side counterpart to the load extension mux in the MEM stage. It accepts a store request carrying a byte/half/word size mask, an unaligned byte address and register data, then shifts data and byte-enables onto word lanes. It issues one or two word-aligned write beats to data memory over a valid/ready handshake, splitting stores that cross a word boundary. It sits between the EX/MEM pipeline register and the data-memory write port.

## Interface
- No parameters; data/address width fixed at 32.
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-high
- st_valid_i  input  1  store request valid
- st_ready_o  output  1  block idle, request accepted when st_valid_i && st_ready_o
- st_addr_i  input  32  byte address
- st_data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- st_mask_i  input  4  size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; all others illegal
- mem_valid_o  output  1  write beat valid
- mem_ready_i  input  1  memory accepts beat when mem_valid_o && mem_ready_i
- mem_addr_o  output  32  word-aligned beat address ([1:0] always 2'b00)
- mem_wdata_o  output  32  lane-aligned write data
- mem_bmask_o  output  4  byte enables, bit n = byte lane n
- st_done_o  output  1  one-cycle pulse, store fully written
- st_err_o  output  1  one-cycle pulse, request rejected, no beat issued

## Operation
- Registers on accept: off = st_addr_i[1:0], base = {st_addr_i[31:2],2'b00}, sdata = {32'd0,st_data_i} << (8*off) (64 bit), smask = {4'd0,st_mask_i} << off (8 bit).
- Beat 0: addr base, data sdata[31:0], mask smask[3:0]. Beat 1: addr base+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000), data sdata[63:32], mask smask[7:4].
- Split needed iff smask[7:4] != 0.
- FSM states IDLE, BEAT0, BEAT1, RESP:
  - IDLE: st_ready_o=1. Accept -> BEAT0 (legal mask, no error) or RESP with err flag (illegal mask, or split needed with MISALIGN_SPLIT_EN undefined).
  - BEAT0: mem_valid_o=1; on mem_ready_i -> BEAT1 if split, else RESP.
  - BEAT1: mem_valid_o=1; on mem_ready_i -> RESP.
  - RESP: st_done_o=1 (or st_err_o=1 if err flag); unconditionally -> IDLE.
- While mem_valid_o=1 and mem_ready_i=0, mem_addr_o/mem_wdata_o/mem_bmask_o are held stable.
- mem_wdata_o, mem_bmask_o, mem_addr_o are 0 whenever mem_valid_o=0.
- st_data_i bits above the size are ignored (masked before shift).
- st_done_o and st_err_o never assert together.

## Timing
- All outputs decoded from registered state; no combinational path from st_*_i or mem_ready_i to any output.
- Reset: state IDLE, mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_bmask_o=0, st_done_o=0, st_err_o=0; st_ready_o=0 while rst_i=1, 1 from first cycle after.
- Reset mid-beat: beat abandoned, no done/err pulse, IDLE next cycle.
- Accept in cycle N -> mem_valid_o in N+1. Aligned store with mem_ready_i=1: beat N+1, st_done_o N+2, st_ready_o N+3. Split with ready=1: beats N+1, N+2, done N+3.
- Error: accept N -> st_err_o N+1, st_ready_o N+2.
- Throughput: one aligned store per 3 cycles.

## Configuration
- MISALIGN_SPLIT_EN defined: boundary-crossing stores split into two beats as above.
- Undefined: BEAT1 unreachable; any request with smask[7:4] != 0 rejected with st_err_o, no beat. In-word misaligned stores (e.g. byte at off 3, half at off 1) still legal.

## Test plan
- Word store addr 0x1000, data 0xDEADBEEF, mask 1111, ready=1 -> one beat addr 0x1000, wdata 0xDEADBEEF, bmask 1111; st_done_o 2 cycles after accept.
- Byte store addr 0x2003, data 0xFFFFFFA5, mask 0001 -> one beat addr 0x2000, wdata 0xA5000000, bmask 1000.
- Half store addr 0x3003, data 0x0000BEEF, mask 0011, split enabled -> beats 0x3000/0xEF000000/1000 then 0x3004/0x000000BE/0001; same request with macro undefined -> st_err_o, mem_valid_o never set.
- Word store addr 0x4002, mem_ready_i low 3 cycles on beat 0 -> outputs stable 0x4000/0xBEEF0000/1100 until ready, then beat 0x4004/0x0000DEAD/0011 (data 0xDEADBEEF).
- Illegal mask 0101 -> st_err_o one cycle after accept, no beat; rst_i pulsed during stalled BEAT1 -> mem_valid_o 0, no done pulse, st_ready_o 1 after reset.
- Word store at 0xFFFFFFFE, split enabled -> second beat addr 0x00000000, bmask 0011.
